// File: rtl/mccu_pkg.sv
// ============================================================================
// mccu_pkg : shared encodings for the multi-cycle control unit
// Rev 1.0  : initial release (MCCU_JAL_EN enables jal decode in mccu_decode/mccu_ctrl)
// ============================================================================
`default_nettype none

package mccu_pkg;

  typedef enum logic [2:0] {
    ST_IF  = 3'b000,
    ST_ID  = 3'b001,
    ST_EXE = 3'b010,
    ST_MEM = 3'b011,
    ST_WB  = 3'b100
  } state_t;

  typedef enum logic [3:0] {
    IC_RALU,
    IC_SHIFT,
    IC_IALU,
    IC_LOAD,
    IC_STORE,
    IC_BRANCH,
    IC_JUMP,
    IC_JR,
    IC_JAL,
    IC_ILLEGAL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REGA   = 2'b11;

endpackage

`default_nettype wire

// File: rtl/mccu_decode.sv
// ============================================================================
// mccu_decode : combinational op/func -> instruction class, aluc, sext
// Rev 1.0     : initial release (jal decoded only when MCCU_JAL_EN is defined)
// ============================================================================
`default_nettype none

module mccu_decode
  import mccu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output iclass_t    iclass,
  output logic [3:0] aluc,
  output logic       sext
);

  always_comb begin
    iclass = IC_ILLEGAL;
    aluc   = ALU_ADD;
    sext   = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  begin iclass = IC_RALU;  aluc = ALU_ADD; end
          FN_SUB:  begin iclass = IC_RALU;  aluc = ALU_SUB; end
          FN_AND:  begin iclass = IC_RALU;  aluc = ALU_AND; end
          FN_OR:   begin iclass = IC_RALU;  aluc = ALU_OR;  end
          FN_XOR:  begin iclass = IC_RALU;  aluc = ALU_XOR; end
          FN_SLL:  begin iclass = IC_SHIFT; aluc = ALU_SLL; end
          FN_SRL:  begin iclass = IC_SHIFT; aluc = ALU_SRL; end
          FN_JR:   iclass = IC_JR;
          default: iclass = IC_ILLEGAL;
        endcase
      end
      OP_ADDI: begin iclass = IC_IALU; aluc = ALU_ADD; sext = 1'b1; end
      OP_ANDI: begin iclass = IC_IALU; aluc = ALU_AND; end
      OP_ORI:  begin iclass = IC_IALU; aluc = ALU_OR;  end
      OP_XORI: begin iclass = IC_IALU; aluc = ALU_XOR; end
      OP_LUI:  begin iclass = IC_IALU; aluc = ALU_LUI; end
      OP_LW:   begin iclass = IC_LOAD;  sext = 1'b1; end
      OP_SW:   begin iclass = IC_STORE; sext = 1'b1; end
      // Branch compares rely on the ALU's xor code being the only one that updates zero.
      OP_BEQ, OP_BNE: begin iclass = IC_BRANCH; aluc = ALU_XOR; end
      OP_J:    iclass = IC_JUMP;
`ifdef MCCU_JAL_EN
      OP_JAL:  iclass = IC_JAL;
`endif
      default: iclass = IC_ILLEGAL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mccu_ctrl.sv
// ============================================================================
// mccu_ctrl : multi-cycle control FSM with memory wait timeout
// Rev 1.0   : initial release (define MCCU_JAL_EN to enable jal support)
// ============================================================================
`default_nettype none

module mccu_ctrl
  import mccu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       wir,
  output logic       wpc,
  output logic       wreg,
  output logic       regrt,
  output logic       m2reg,
  output logic [3:0] aluc,
  output logic       shift,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       sext,
  output logic [1:0] pcsrc,
  output logic       jal,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt;
  iclass_t       iclass;
  logic [3:0]    dec_aluc;
  logic          dec_sext;
  logic          waiting, timeout;
  logic          req_c, we_c, wir_c, wpc_c, wreg_c, ill_c, berr_c;

  mccu_decode u_decode (
    .op     (op),
    .func   (func),
    .iclass (iclass),
    .aluc   (dec_aluc),
    .sext   (dec_sext)
  );

  assign waiting = ((state_q == ST_IF) || (state_q == ST_MEM)) && !mem_ready;
  assign timeout = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q  <= ST_IF;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) || timeout)
        wait_cnt <= '0;
      else if (waiting)
        wait_cnt <= wait_cnt + CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    we_c    = 1'b0;
    wir_c   = 1'b0;
    wpc_c   = 1'b0;
    wreg_c  = 1'b0;
    ill_c   = 1'b0;
    berr_c  = 1'b0;
    iord    = 1'b0;
    regrt   = 1'b0;
    m2reg   = 1'b0;
    aluc    = ALU_ADD;
    shift   = 1'b0;
    alusrca = 1'b0;
    alusrcb = SRCB_B;
    sext    = 1'b0;
    pcsrc   = PC_ALU;
    jal     = 1'b0;
    case (state_q)
      ST_IF: begin
        alusrcb = SRCB_FOUR;
        req_c   = !timeout;
        berr_c  = timeout;
        if (mem_ready) begin
          wir_c   = 1'b1;
          wpc_c   = 1'b1;
          state_d = ST_ID;
        end
      end
      ST_ID: begin
        // PC + (sext imm << 2) is computed here so a branch target sits in ALUOut for EXE.
        alusrcb = SRCB_BRANCH;
        sext    = 1'b1;
        state_d = ST_EXE;
        case (iclass)
          IC_JUMP: begin wpc_c = 1'b1; pcsrc = PC_JUMP; state_d = ST_IF; end
          IC_JR:   begin wpc_c = 1'b1; pcsrc = PC_REGA; state_d = ST_IF; end
          IC_ILLEGAL: begin ill_c = 1'b1; state_d = ST_IF; end
`ifdef MCCU_JAL_EN
          IC_JAL: begin
            wpc_c   = 1'b1;
            pcsrc   = PC_JUMP;
            wreg_c  = 1'b1;
            jal     = 1'b1;
            state_d = ST_IF;
          end
`endif
          default: state_d = ST_EXE;
        endcase
      end
      ST_EXE: begin
        alusrca = 1'b1;
        aluc    = dec_aluc;
        sext    = dec_sext;
        state_d = ST_WB;
        case (iclass)
          IC_RALU:  state_d = ST_WB;
          IC_SHIFT: begin alusrca = 1'b0; shift = 1'b1; end
          IC_IALU:  alusrcb = SRCB_IMM;
          IC_LOAD, IC_STORE: begin alusrcb = SRCB_IMM; state_d = ST_MEM; end
          IC_BRANCH: begin
            pcsrc   = PC_ALUOUT;
            wpc_c   = (op == OP_BNE) ? !zero : zero;
            state_d = ST_IF;
          end
          default: state_d = ST_IF;
        endcase
      end
      ST_MEM: begin
        iord  = 1'b1;
        req_c = !timeout;
        we_c  = (iclass == IC_STORE) && !timeout;
        if (mem_ready)
          state_d = (iclass == IC_STORE) ? ST_IF : ST_WB;
        else if (timeout)
          state_d = ST_IF;
      end
      ST_WB: begin
        wreg_c  = 1'b1;
        regrt   = (iclass == IC_IALU) || (iclass == IC_LOAD);
        m2reg   = (iclass == IC_LOAD);
        state_d = ST_IF;
      end
      default: state_d = ST_IF;
    endcase
  end

  // Anything that commits state outside the controller is held off during reset.
  assign mem_req = req_c  & clrn;
  assign mem_we  = we_c   & clrn;
  assign wir     = wir_c  & clrn;
  assign wpc     = wpc_c  & clrn;
  assign wreg    = wreg_c & clrn;
  assign illegal = ill_c  & clrn;
  assign bus_err = berr_c & clrn;
  assign state   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mccu_ctrl.sv
// ============================================================================
// tb_mccu_ctrl : randomized self-checking bench for mccu_ctrl
// Rev 1.0      : initial release (honours MCCU_JAL_EN)
// ============================================================================
`default_nettype none

module tb_mccu_ctrl;

  localparam int T = 4;

  localparam int P_IF = 0, P_ID = 1, P_EXE = 2, P_MEM = 3, P_WB = 4;
  localparam int K_RALU = 0, K_SHIFT = 1, K_IALU = 2, K_LW = 3, K_SW = 4,
                 K_BEQ = 5, K_BNE = 6, K_J = 7, K_JR = 8, K_JAL = 9, K_ILL = 10;
  localparam int N_ENT = 21;

  typedef struct {
    logic [5:0] op;
    logic [5:0] func;
    bit         fix_func;
    int         kind;
    logic [3:0] aluc;
    bit         sx;
    string      name;
  } ent_t;

  typedef struct packed {
    logic       mem_req, mem_we, iord, wir, wpc, wreg, regrt, m2reg;
    logic [3:0] aluc;
    logic       shift, alusrca;
    logic [1:0] alusrcb;
    logic       sext;
    logic [1:0] pcsrc;
    logic       jal, illegal, bus_err;
  } ov_t;

  logic       clk = 1'b0, clrn = 1'b0;
  logic [5:0] op = '0, func = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, wir, wpc, wreg, regrt, m2reg;
  logic [3:0] aluc;
  logic       shift, alusrca, sext, jal, illegal, bus_err;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  mccu_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .clrn(clrn), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .wir(wir), .wpc(wpc), .wreg(wreg),
    .regrt(regrt), .m2reg(m2reg), .aluc(aluc), .shift(shift), .alusrca(alusrca),
    .alusrcb(alusrcb), .sext(sext), .pcsrc(pcsrc), .jal(jal), .illegal(illegal),
    .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ent_t mk(logic [5:0] o, logic [5:0] f, bit fx, int k,
                              logic [3:0] a, bit s, string n);
    ent_t e;
    e.op = o; e.func = f; e.fix_func = fx; e.kind = k; e.aluc = a; e.sx = s; e.name = n;
    return e;
  endfunction

  function automatic ent_t entry(int i);
    case (i)
      0:  return mk(6'b000000, 6'b100000, 1, K_RALU,  4'b0000, 0, "add");
      1:  return mk(6'b000000, 6'b100010, 1, K_RALU,  4'b0100, 0, "sub");
      2:  return mk(6'b000000, 6'b100100, 1, K_RALU,  4'b0001, 0, "and");
      3:  return mk(6'b000000, 6'b100101, 1, K_RALU,  4'b0101, 0, "or");
      4:  return mk(6'b000000, 6'b100110, 1, K_RALU,  4'b0010, 0, "xor");
      5:  return mk(6'b000000, 6'b000000, 1, K_SHIFT, 4'b0011, 0, "sll");
      6:  return mk(6'b000000, 6'b000010, 1, K_SHIFT, 4'b0111, 0, "srl");
      7:  return mk(6'b000000, 6'b001000, 1, K_JR,    4'b0000, 0, "jr");
      8:  return mk(6'b001000, 6'b000000, 0, K_IALU,  4'b0000, 1, "addi");
      9:  return mk(6'b001100, 6'b000000, 0, K_IALU,  4'b0001, 0, "andi");
      10: return mk(6'b001101, 6'b000000, 0, K_IALU,  4'b0101, 0, "ori");
      11: return mk(6'b001110, 6'b000000, 0, K_IALU,  4'b0010, 0, "xori");
      12: return mk(6'b001111, 6'b000000, 0, K_IALU,  4'b0110, 0, "lui");
      13: return mk(6'b100011, 6'b000000, 0, K_LW,    4'b0000, 1, "lw");
      14: return mk(6'b101011, 6'b000000, 0, K_SW,    4'b0000, 1, "sw");
      15: return mk(6'b000100, 6'b000000, 0, K_BEQ,   4'b0010, 0, "beq");
      16: return mk(6'b000101, 6'b000000, 0, K_BNE,   4'b0010, 0, "bne");
      17: return mk(6'b000010, 6'b000000, 0, K_J,     4'b0000, 0, "j");
`ifdef MCCU_JAL_EN
      18: return mk(6'b000011, 6'b000000, 0, K_JAL,   4'b0000, 0, "jal");
`else
      18: return mk(6'b000011, 6'b000000, 0, K_ILL,   4'b0000, 0, "jal_off");
`endif
      19: return mk(6'b111111, 6'b000000, 0, K_ILL,   4'b0000, 0, "bad_op");
      default: return mk(6'b000000, 6'b111111, 1, K_ILL, 4'b0000, 0, "bad_func");
    endcase
  endfunction

  // Expected cycles per instruction with no memory wait.
  function automatic int base_cycles(int k);
    if (k == K_J || k == K_JR || k == K_JAL || k == K_ILL) return 2;
    if (k == K_BEQ || k == K_BNE) return 3;
    if (k == K_LW) return 5;
    return 4;
  endfunction

  function automatic int next_phase(int ph, int k, bit rdy, bit to);
    case (ph)
      P_IF:  return rdy ? P_ID : P_IF;
      P_ID:  return (base_cycles(k) == 2) ? P_IF : P_EXE;
      P_EXE: return (k == K_BEQ || k == K_BNE) ? P_IF : (k == K_LW || k == K_SW) ? P_MEM : P_WB;
      P_MEM: return rdy ? ((k == K_LW) ? P_WB : P_IF) : (to ? P_IF : P_MEM);
      default: return P_IF;
    endcase
  endfunction

  function automatic ov_t expect_out(int ph, ent_t en, bit z, bit rdy, bit to);
    ov_t e;
    e = '0;
    case (ph)
      P_IF: begin
        e.alusrcb = 2'b01;
        e.bus_err = to;
        e.mem_req = !to;
        e.wir = rdy;
        e.wpc = rdy;
      end
      P_ID: begin
        e.alusrcb = 2'b11;
        e.sext = 1'b1;
        if (en.kind == K_J)   begin e.wpc = 1'b1; e.pcsrc = 2'b10; end
        if (en.kind == K_JR)  begin e.wpc = 1'b1; e.pcsrc = 2'b11; end
        if (en.kind == K_JAL) begin e.wpc = 1'b1; e.pcsrc = 2'b10; e.wreg = 1'b1; e.jal = 1'b1; end
        if (en.kind == K_ILL) e.illegal = 1'b1;
      end
      P_EXE: begin
        e.aluc = en.aluc;
        case (en.kind)
          K_RALU:  e.alusrca = 1'b1;
          K_SHIFT: e.shift = 1'b1;
          K_IALU:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.sext = en.sx; end
          K_LW, K_SW: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.sext = 1'b1; end
          default: begin
            e.alusrca = 1'b1;
            e.pcsrc = 2'b01;
            e.wpc = (en.kind == K_BEQ) ? z : !z;
          end
        endcase
      end
      P_MEM: begin
        e.iord = 1'b1;
        e.mem_req = !to;
        e.mem_we = !to && (en.kind == K_SW);
      end
      default: begin
        e.wreg = 1'b1;
        e.regrt = (en.kind == K_IALU) || (en.kind == K_LW);
        e.m2reg = (en.kind == K_LW);
      end
    endcase
    return e;
  endfunction

  // Runs one instruction from its fetch cycle; entered and left at posedge+1 in IF.
  task automatic run_instr(input int idx, input int if_w, input int mem_w, input bit z);
    ent_t en;
    ov_t  e, a;
    int   ph, nxt, wc, cyc, exp_cyc;
    bit   rdy, to, aborted, done;
    en = entry(idx);
    ph = P_IF; wc = 0; cyc = 0; aborted = 0; done = 0;
    exp_cyc = base_cycles(en.kind) + if_w + ((en.kind == K_LW || en.kind == K_SW) ? mem_w : 0);
    op   = en.op;
    func = en.fix_func ? en.func : 6'($urandom);
    zero = z;
    while (!done) begin
      if (ph == P_IF)       rdy = (wc >= if_w);
      else if (ph == P_MEM) rdy = (wc >= mem_w);
      else                  rdy = 1'($urandom);
      mem_ready = rdy;
      #3;
      to = (ph == P_IF || ph == P_MEM) && !rdy && (wc == T - 1);
      e  = expect_out(ph, en, z, rdy, to);
      a  = {mem_req, mem_we, iord, wir, wpc, wreg, regrt, m2reg, aluc, shift, alusrca,
            alusrcb, sext, pcsrc, jal, illegal, bus_err};
      check({en.name, "/state"}, 32'(state), 32'(ph));
      check({en.name, "/outs"}, 32'(a), 32'(e));
      nxt = next_phase(ph, en.kind, rdy, to);
      if (to) begin
        aborted = 1;
        if (ph == P_IF) if_w = 0;
      end
      if (nxt != ph || to) wc = 0;
      else wc++;
      cyc++;
      done = (nxt == P_IF && ph != P_IF) || (cyc > 40);
      ph = nxt;
      @(posedge clk);
      #1;
    end
    if (cyc > 40) check({en.name, "/bound"}, 32'(cyc), 32'd40);
    else if (!aborted) check({en.name, "/cycles"}, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    clrn = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst/state", 32'(state), 32'd0);
    check("rst/mem_req", 32'(mem_req), 32'd0);
    check("rst/wir", 32'(wir), 32'd0);
    clrn = 1'b1;

    run_instr(0, 0, 0, 0);
    run_instr(15, 0, 0, 1);
    run_instr(15, 0, 0, 0);
    run_instr(16, 0, 0, 0);
    run_instr(13, 0, 3, 0);
    run_instr(0, T, 0, 0);
    run_instr(8, T - 1, 0, 0);
    run_instr(14, 0, T, 0);
    run_instr(13, 0, T - 1, 0);
    run_instr(19, 0, 0, 0);
    run_instr(20, 1, 0, 0);
    run_instr(18, 0, 0, 0);
    run_instr(17, 2, 0, 0);
    run_instr(7, 0, 0, 0);

    repeat (300)
      run_instr($urandom_range(0, N_ENT - 1), $urandom_range(0, T), $urandom_range(0, T),
                1'($urandom));

    // Reset while a store is in MEM: request must drop at once, fetch resumes after release.
    op = 6'b101011;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    clrn = 1'b0;
    #3;
    check("swrst/state", 32'(state), 32'd3);
    check("swrst/mem_req", 32'(mem_req), 32'd0);
    check("swrst/mem_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    #3;
    check("swrst/post_state", 32'(state), 32'd0);
    check("swrst/post_req", 32'(mem_req), 32'd1);
    check("swrst/post_iord", 32'(iord), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
